// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU run controller slice.
//   run_state_t : controller state encoding (IDLE = 0, RUN = 1, HALTED = 2)
//   DEF_DIV_W   : default width of the free-run rate divider
//   DEF_CNT_W   : default width of the executed-step counter
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } run_state_t;

    localparam int DEF_DIV_W = 24;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/tick_div.sv
// ----------------------------------------------------------------------------
// tick_div
// Free-run rate divider. Counts while enabled and raises a one-cycle tick
// when the count has reached the compare value; the count self-clears on
// the tick so the period is rate_div + 1 cycles.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   clr      : clear the count (run start / run stop)
//   en       : count enable (controller is in RUN)
//   rate_div : compare value, sampled live every cycle
//   tick     : one-cycle tick, high while en and count >= rate_div
// ----------------------------------------------------------------------------
module tick_div
    import cpu_ctrl_pkg::*;
#(
    parameter int W = DEF_DIV_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] rate_div,
    output logic         tick
);

    logic [W-1:0] r_count;

    // Greater-or-equal rather than equality: if rate_div is lowered below
    // the current count, the divider fires at once instead of wrapping.
    assign tick = en && (r_count >= rate_div);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr || tick) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
// Turns debounced button pulses into a registered CPU clock-enable.
// Modes: single-step from IDLE, periodic free-run in RUN, and a sticky
// HALTED state entered whenever the CPU reports halt.
// Ports:
//   clk        : system clock, single domain
//   reset_n    : synchronous active-low reset
//   step_pulse : one-cycle request for a single step (IDLE only)
//   run_pulse  : one-cycle toggle between IDLE and RUN
//   rate_div   : free-run period minus one, in clk cycles
//   cpu_halt   : CPU has executed halt (level)
//   cpu_en     : registered one-cycle CPU clock-enable
//   running    : high while in RUN
//   halted     : high while in HALTED
//   step_count : number of cpu_en pulses issued since reset, wrapping
// All outputs are registers; no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_pulse,
    input  logic             run_pulse,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             cpu_halt,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    run_state_t       r_state;
    run_state_t       w_stateNext;
    logic             w_cpuEnNext;
    logic             r_cpuEn;
    logic             r_running;
    logic             r_halted;
    logic [CNT_W-1:0] r_stepCount;
    logic             w_divClr;
    logic             w_divEn;
    logic             w_tick;

    assign w_divEn = (r_state == RUN);

    tick_div #(
        .W (DIV_W)
    ) u_tick_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (w_divClr),
        .en       (w_divEn),
        .rate_div (rate_div),
        .tick     (w_tick)
    );

    // Next-state and next-enable decode. Halt is checked first in every
    // state so it wins over any simultaneous button pulse; run beats step
    // in IDLE, and a run toggle never issues a pulse in its own cycle.
    always_comb begin
        w_stateNext = r_state;
        w_cpuEnNext = 1'b0;
        w_divClr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_halt) begin
                    w_stateNext = HALTED;
                end else if (run_pulse) begin
                    w_stateNext = RUN;
                    w_divClr    = 1'b1;
                end else if (step_pulse) begin
                    w_cpuEnNext = 1'b1;
                end
            end
            RUN: begin
                if (cpu_halt) begin
                    w_stateNext = HALTED;
                end else if (run_pulse) begin
                    w_stateNext = IDLE;
                    w_divClr    = 1'b1;
                end else begin
                    w_cpuEnNext = w_tick;
                end
            end
            HALTED: begin
                w_stateNext = HALTED;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State, enable and status registers. The status flags are loaded from
    // the next-state decode so they line up with the state register itself.
    // The step counter follows cpu_en by one cycle and wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cpuEn     <= 1'b0;
            r_running   <= 1'b0;
            r_halted    <= 1'b0;
            r_stepCount <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_cpuEn   <= w_cpuEnNext;
            r_running <= (w_stateNext == RUN);
            r_halted  <= (w_stateNext == HALTED);
            if (r_cpuEn) begin
                r_stepCount <= r_stepCount + CNT_W'(1);
            end
        end
    end

    assign cpu_en     = r_cpuEn;
    assign running    = r_running;
    assign halted     = r_halted;
    assign step_count = r_stepCount;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl. Stimulus pushes the edge index at which
// each cpu_en pulse must appear (plus the step_count it must carry) into a
// queue; an independent monitor checks every cycle for expected, missing
// and unexpected pulses. A second instance with CNT_W = 4 covers wrapping.
// ----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    typedef struct {
        int          edgeIdx;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stepPulse = 1'b0;
    logic        runPulse = 1'b0;
    logic        cpuHalt = 1'b0;
    logic [23:0] rateDiv = 24'd0;
    logic        cpuEn;
    logic        running;
    logic        halted;
    logic [15:0] stepCount;

    logic        step2 = 1'b0;
    logic        run2 = 1'b0;
    logic        halt2 = 1'b0;
    logic [7:0]  rateDiv2 = 8'd0;
    logic        cpuEn2;
    logic        running2;
    logic        halted2;
    logic [3:0]  stepCount2;

    exp_t        expQ[$];
    logic [15:0] expCount = 16'd0;
    int          checks = 0;
    int          failures = 0;
    int          edgeCnt = 0;

    cpu_run_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .step_pulse (stepPulse),
        .run_pulse  (runPulse),
        .rate_div   (rateDiv),
        .cpu_halt   (cpuHalt),
        .cpu_en     (cpuEn),
        .running    (running),
        .halted     (halted),
        .step_count (stepCount)
    );

    cpu_run_ctrl #(
        .DIV_W (8),
        .CNT_W (4)
    ) dutWrap (
        .clk        (clk),
        .reset_n    (reset_n),
        .step_pulse (step2),
        .run_pulse  (run2),
        .rate_div   (rateDiv2),
        .cpu_halt   (halt2),
        .cpu_en     (cpuEn2),
        .running    (running2),
        .halted     (halted2),
        .step_count (stepCount2)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Edge index: at any falling edge this holds the number of rising edges
    // so far, so a pulse registered at rising edge N is seen with edgeCnt == N.
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Monitor: drops and reports any expected pulse whose edge has passed,
    // checks a pulse due now, and flags cpu_en high when nothing was due.
    always @(negedge clk) begin
        exp_t cur;
        while (expQ.size() > 0 && expQ[0].edgeIdx < edgeCnt) begin
            checks++;
            failures++;
            $display("[TB] FAIL missedPulse: edge %0d cpu_en=0 required 1", expQ[0].edgeIdx);
            void'(expQ.pop_front());
        end
        if (expQ.size() > 0 && expQ[0].edgeIdx == edgeCnt) begin
            cur = expQ.pop_front();
            checks++;
            if (cpuEn !== 1'b1 || stepCount !== cur.cnt) begin
                failures++;
                $display("[TB] FAIL pulse@%0d: cpu_en=%b step_count=%0d required cpu_en=1 step_count=%0d",
                         edgeCnt, cpuEn, stepCount, cur.cnt);
            end
        end else if (cpuEn !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedPulse@%0d: cpu_en=%b required 0", edgeCnt, cpuEn);
        end
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExp(input int e);
        exp_t item;
        item.edgeIdx = e;
        item.cnt     = expCount;
        expQ.push_back(item);
        expCount = expCount + 16'd1;
    endtask

    task automatic waitEdge(input int target);
        while (edgeCnt < target) @(negedge clk);
    endtask

    // Drive the button pulses for one cycle; e is the rising edge that samples them.
    task automatic applyStimulus(input logic s, input logic r, output int e);
        e         = edgeCnt + 1;
        stepPulse = s;
        runPulse  = r;
        @(negedge clk);
        stepPulse = 1'b0;
        runPulse  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, required);
        end
    endtask

    initial begin
        int e;
        int eAux;

        // Reset state.
        @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("rstCpuEn", 32'(cpuEn), 0);
        checkOutput("rstRunning", 32'(running), 0);
        checkOutput("rstHalted", 32'(halted), 0);
        checkOutput("rstStepCount", 32'(stepCount), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Three single steps, five cycles apart.
        $display("[TB] single-step in IDLE");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, e);
            pushExp(e);
            repeat (4) @(negedge clk);
        end
        checkOutput("stepCount3", 32'(stepCount), 3);

        // Free-run with rate_div = 3: period 4, first pulse four edges after start.
        $display("[TB] free-run rate_div=3");
        rateDiv = 24'd3;
        applyStimulus(1'b0, 1'b1, e);
        pushExp(e + 4);
        pushExp(e + 8);
        pushExp(e + 12);
        checkOutput("runningOn", 32'(running), 1);
        waitEdge(e + 13);
        checkOutput("runningBeforeStop", 32'(running), 1);
        applyStimulus(1'b0, 1'b1, eAux);
        checkOutput("runningOff", 32'(running), 0);
        repeat (10) @(negedge clk);
        checkOutput("stepCount6", 32'(stepCount), 6);

        // rate_div = 0 runs continuously; then a long period is cut short.
        $display("[TB] free-run rate_div=0 then live rate change");
        rateDiv = 24'd0;
        applyStimulus(1'b0, 1'b1, e);
        for (int k = 1; k <= 8; k++) pushExp(e + k);
        pushExp(e + 509);
        pushExp(e + 512);
        pushExp(e + 515);
        waitEdge(e + 8);
        rateDiv = 24'd1000;
        waitEdge(e + 508);
        rateDiv = 24'd2;
        waitEdge(e + 515);
        applyStimulus(1'b0, 1'b1, eAux);
        checkOutput("runningOff2", 32'(running), 0);
        repeat (8) @(negedge clk);
        checkOutput("stepCount17", 32'(stepCount), 17);

        // Step and run together: run wins; a step during RUN is ignored.
        $display("[TB] step+run collision, step in RUN, halt on due pulse");
        rateDiv = 24'd3;
        applyStimulus(1'b1, 1'b1, e);
        pushExp(e + 4);
        pushExp(e + 8);
        checkOutput("runningAfterBoth", 32'(running), 1);
        waitEdge(e + 5);
        applyStimulus(1'b1, 1'b0, eAux);

        // Halt sampled exactly when the next run pulse is due at e + 12.
        waitEdge(e + 11);
        cpuHalt = 1'b1;
        @(negedge clk);
        checkOutput("haltedSet", 32'(halted), 1);
        checkOutput("haltCpuEn", 32'(cpuEn), 0);
        checkOutput("haltRunning", 32'(running), 0);
        cpuHalt = 1'b0;
        applyStimulus(1'b0, 1'b1, eAux);
        applyStimulus(1'b1, 1'b0, eAux);
        repeat (4) @(negedge clk);
        checkOutput("haltSticky", 32'(halted), 1);
        checkOutput("haltStickyRunning", 32'(running), 0);
        checkOutput("stepCount19", 32'(stepCount), 19);

        // Reset leaves HALTED and clears the counter.
        reset_n = 1'b0;
        @(negedge clk);
        expCount = 16'd0;
        checkOutput("rst2Halted", 32'(halted), 0);
        checkOutput("rst2Running", 32'(running), 0);
        checkOutput("rst2StepCount", 32'(stepCount), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Step counter wrap on the 4-bit instance.
        $display("[TB] step_count wrap with CNT_W=4");
        for (int i = 0; i < 17; i++) begin
            step2 = 1'b1;
            @(negedge clk);
            step2 = 1'b0;
            @(negedge clk);
            if (i == 15) checkOutput("wrapAt16", 32'(stepCount2), 0);
        end
        repeat (2) @(negedge clk);
        checkOutput("wrapAt17", 32'(stepCount2), 1);
        checkOutput("wrapRunning", 32'(running2), 0);
        checkOutput("wrapHalted", 32'(halted2), 0);
        checkOutput("wrapCpuEnIdle", 32'(cpuEn2), 0);

        repeat (4) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
